// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_pkg;

  localparam int unsigned D         = 10;
  localparam int unsigned START_IDX = 10;
  localparam int unsigned LUT_DEPTH = 16;
  localparam int unsigned IDX_W     = $clog2(LUT_DEPTH);
  localparam int unsigned RAS_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/ret_stack.sv
// LIFO return-address stack; top-of-stack read is combinational.
module ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] sp_q, sp_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign full    = (sp_q == PW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign wr_idx  = sp_q[AW-1:0];
  assign top_idx = AW'(sp_q - PW'(1));
  assign top_data = mem_q[top_idx];

  // Pointer and storage update; clear beats push beats pop, guarded by full/empty.
  always_comb begin
    sp_d = sp_q;
    for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = mem_q[i];
    if (clear) begin
      sp_d = '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = '0;
    end else if (push && !full) begin
      mem_d[wr_idx] = push_data;
      sp_d          = sp_q + PW'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - PW'(1);
    end
  end

  // Stack state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      sp_q <= sp_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/pc_branch_ctrl.sv
// PC sequencer: sequential fetch, LUT branches, call/return, stall and halt.
module pc_branch_ctrl #(
  parameter int unsigned D         = pc_pkg::D,
  parameter int unsigned START_IDX = pc_pkg::START_IDX,
  parameter int unsigned RAS_DEPTH = pc_pkg::RAS_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stall,
  input  logic                     branch_en,
  input  logic                     taken,
  input  logic                     is_call,
  input  logic                     is_ret,
  input  logic [pc_pkg::IDX_W-1:0] branch_idx,
  input  logic                     halt_req,
  output logic [pc_pkg::IDX_W-1:0] lut_addr,
  input  logic [D-1:0]             lut_target,
  output logic [D-1:0]             pc,
  output logic                     running,
  output logic                     done,
  output logic                     err_ovf,
  output logic                     err_unf
);

  import pc_pkg::*;

  state_e       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         running_q, running_d;
  logic         done_q, done_d;
  logic         err_ovf_q, err_ovf_d;
  logic         err_unf_q, err_unf_d;

  logic         rs_clear, rs_push, rs_pop;
  logic         rs_full, rs_empty;
  logic [D-1:0] rs_top;
  logic [D-1:0] pc_inc;

  assign pc_inc = pc_q + D'(1);

  ret_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (D)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (rs_clear),
    .push      (rs_push),
    .pop       (rs_pop),
    .push_data (pc_inc),
    .top_data  (rs_top),
    .full      (rs_full),
    .empty     (rs_empty)
  );

  // LUT index: entry point while idle, decoded branch index otherwise.
  assign lut_addr = (state_q == ST_IDLE) ? IDX_W'(START_IDX) : branch_idx;

  // Next-state, next-pc mux and stack control.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    rs_clear  = 1'b0;
    rs_push   = 1'b0;
    rs_pop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = lut_target;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (halt_req) begin
            state_d = ST_HALTED;
          end else if (branch_en && is_call) begin
            pc_d = lut_target;
            if (rs_full) err_ovf_d = 1'b1;
            else         rs_push   = 1'b1;
          end else if (branch_en && is_ret) begin
            if (rs_empty) begin
              pc_d      = pc_inc;
              err_unf_d = 1'b1;
            end else begin
              pc_d   = rs_top;
              rs_pop = 1'b1;
            end
          end else if (branch_en && taken) begin
            pc_d = lut_target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      ST_HALTED: begin
        if (start) begin
          state_d   = ST_IDLE;
          rs_clear  = 1'b1;
          err_ovf_d = 1'b0;
          err_unf_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_HALTED);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign pc      = pc_q;
  assign running = running_q;
  assign done    = done_q;
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed self-checking bench for pc_branch_ctrl with a behavioural LUT.
module tb_pc_branch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start, stall, branch_en, taken, is_call, is_ret, halt_req;
  logic [3:0] branch_idx;
  logic [3:0] lut_addr;
  logic [9:0] lut_target;
  logic [9:0] pc;
  logic       running, done, err_ovf, err_unf;

  logic [9:0] lut [16];
  int         checks;
  int         failures;

  assign lut_target = lut[lut_addr];

  pc_branch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stall      (stall),
    .branch_en  (branch_en),
    .taken      (taken),
    .is_call    (is_call),
    .is_ret     (is_ret),
    .branch_idx (branch_idx),
    .halt_req   (halt_req),
    .lut_addr   (lut_addr),
    .lut_target (lut_target),
    .pc         (pc),
    .running    (running),
    .done       (done),
    .err_ovf    (err_ovf),
    .err_unf    (err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; stall = 0; branch_en = 0; taken = 0;
    is_call = 0; is_ret = 0; halt_req = 0; branch_idx = 0;
  endtask

  task automatic do_call(input logic [3:0] idx);
    branch_en = 1; is_call = 1; branch_idx = idx;
    tick();
    idle_in();
  endtask

  task automatic do_ret();
    branch_en = 1; is_ret = 1;
    tick();
    idle_in();
  endtask

  task automatic do_jump(input logic [3:0] idx, input logic tk);
    branch_en = 1; taken = tk; branch_idx = idx;
    tick();
    idle_in();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) lut[i] = 10'(i * 7);
    lut[10] = 10'd1;
    lut[2]  = 10'd80;
    lut[3]  = 10'd68;
    lut[11] = 10'd5;
    lut[12] = 10'd20;
    lut[4]  = 10'd200;
    lut[5]  = 10'd300;
    lut[6]  = 10'd400;
    lut[7]  = 10'd500;
    lut[8]  = 10'd600;
    lut[9]  = 10'd1023;

    idle_in();
    rst_n = 0;
    #12;
    check_eq("rst_pc", pc, 0);
    check_eq("rst_running", running, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err_ovf", err_ovf, 0);
    check_eq("rst_err_unf", err_unf, 0);
    rst_n = 1;
    tick();

    // Start: entry point from LUT[10]
    check_eq("idle_lut_addr", lut_addr, 10);
    start = 1;
    tick();
    idle_in();
    check_eq("start_pc", pc, 1);
    check_eq("start_running", running, 1);
    tick(); check_eq("seq_pc2", pc, 2);
    tick(); check_eq("seq_pc3", pc, 3);
    tick(); check_eq("seq_pc4", pc, 4);
    tick(); check_eq("seq_pc5", pc, 5);

    // Taken and not-taken branch from pc=5
    branch_en = 1; taken = 1; branch_idx = 2;
    #1 check_eq("run_lut_addr", lut_addr, 2);
    tick();
    idle_in();
    check_eq("taken_pc", pc, 80);
    do_jump(4'd11, 1'b1);
    check_eq("back_to_5", pc, 5);
    do_jump(4'd2, 1'b0);
    check_eq("not_taken_pc", pc, 6);

    // Call and return
    do_jump(4'd12, 1'b1);
    check_eq("goto_20", pc, 20);
    do_call(4'd3);
    check_eq("call_pc", pc, 68);
    tick(); tick();
    check_eq("pc_70", pc, 70);
    do_ret();
    check_eq("ret_pc", pc, 21);

    // Five nested calls, five returns
    do_call(4'd4); check_eq("call1", pc, 200);
    do_call(4'd5); check_eq("call2", pc, 300);
    do_call(4'd6); check_eq("call3", pc, 400);
    do_call(4'd7); check_eq("call4", pc, 500);
    check_eq("no_ovf_yet", err_ovf, 0);
    do_call(4'd8); check_eq("call5_pc", pc, 600);
    check_eq("ovf_set", err_ovf, 1);
    do_ret(); check_eq("ret1", pc, 401);
    do_ret(); check_eq("ret2", pc, 301);
    do_ret(); check_eq("ret3", pc, 201);
    do_ret(); check_eq("ret4", pc, 22);
    check_eq("no_unf_yet", err_unf, 0);
    do_ret(); check_eq("ret5_pc", pc, 23);
    check_eq("unf_set", err_unf, 1);
    check_eq("ovf_sticky", err_ovf, 1);

    // Halt beats a taken branch
    halt_req = 1; branch_en = 1; taken = 1; branch_idx = 2;
    tick();
    idle_in();
    check_eq("halt_pc", pc, 23);
    check_eq("halt_done", done, 1);
    check_eq("halt_running", running, 0);
    tick();
    check_eq("halted_hold_pc", pc, 23);
    start = 1;
    tick();
    idle_in();
    check_eq("restart_done", done, 0);
    check_eq("restart_pc_held", pc, 23);
    check_eq("restart_ovf_clr", err_ovf, 0);
    check_eq("restart_unf_clr", err_unf, 0);
    check_eq("restart_lut_addr", lut_addr, 10);
    start = 1;
    tick();
    idle_in();
    check_eq("reload_pc", pc, 1);
    check_eq("reload_running", running, 1);

    // Stack cleared by restart: ret underflows
    do_ret();
    check_eq("cleared_stack_pc", pc, 2);
    check_eq("cleared_stack_unf", err_unf, 1);

    // Wrap at 1023
    do_jump(4'd9, 1'b1);
    check_eq("pc_1023", pc, 1023);
    tick();
    check_eq("wrap_pc", pc, 0);

    // Stall freezes pc with a branch pending
    stall = 1; branch_en = 1; taken = 1; branch_idx = 2;
    tick();
    check_eq("stall_pc1", pc, 0);
    is_call = 1;
    tick();
    check_eq("stall_pc2", pc, 0);
    is_call = 0;
    stall = 0;
    tick();
    idle_in();
    check_eq("unstall_pc", pc, 80);
    tick();
    check_eq("after_unstall", pc, 81);

    // Asynchronous reset mid-run
    #2;
    rst_n = 0;
    #1;
    check_eq("async_rst_pc", pc, 0);
    check_eq("async_rst_running", running, 0);
    check_eq("async_rst_err_unf", err_unf, 0);
    check_eq("async_rst_done", done, 0);
    tick();
    check_eq("rst_idle_lut_addr", lut_addr, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
